// File: rtl/dcache_port_arbiter_if.sv
// Bundle of the RF request port, DMA request port and the shared dcache memory port.
// The slave modport is the arbiter's view; master is the view of the logic around it.
interface dcache_port_arbiter_if #(
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned STRIDE_W = 14,
   parameter int unsigned DATA_W   = 288
);
   // Regfile load/store requester
   logic                rf_valid;
   logic                rf_ready;
   logic                rf_we;
   logic [ADDR_W-1:0]   rf_addr;
   logic [STRIDE_W-1:0] rf_stride_x;
   logic [STRIDE_W-1:0] rf_stride_y;
   logic [DATA_W-1:0]   rf_dat_w;
   logic                rf_rvalid;
   logic [DATA_W-1:0]   rf_dat_r;
   // DMA requester
   logic                dma_valid;
   logic                dma_ready;
   logic                dma_we;
   logic [ADDR_W-1:0]   dma_addr;
   logic [DATA_W-1:0]   dma_dat_w;
   logic                dma_rvalid;
   logic [DATA_W-1:0]   dma_dat_r;
   // Shared memory port
   logic                mem_en;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [STRIDE_W-1:0] mem_stride_x;
   logic [STRIDE_W-1:0] mem_stride_y;
   logic [DATA_W-1:0]   mem_dat_w;
   logic [DATA_W-1:0]   mem_dat_r;

   modport slave (
      input  rf_valid, rf_we, rf_addr, rf_stride_x, rf_stride_y, rf_dat_w,
      output rf_ready, rf_rvalid, rf_dat_r,
      input  dma_valid, dma_we, dma_addr, dma_dat_w,
      output dma_ready, dma_rvalid, dma_dat_r,
      output mem_en, mem_we, mem_addr, mem_stride_x, mem_stride_y, mem_dat_w,
      input  mem_dat_r
   );

   modport master (
      output rf_valid, rf_we, rf_addr, rf_stride_x, rf_stride_y, rf_dat_w,
      input  rf_ready, rf_rvalid, rf_dat_r,
      output dma_valid, dma_we, dma_addr, dma_dat_w,
      input  dma_ready, dma_rvalid, dma_dat_r,
      input  mem_en, mem_we, mem_addr, mem_stride_x, mem_stride_y, mem_dat_w,
      output mem_dat_r
   );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Shares the tile dcache port between the regfile path (RF) and the DMA engine.
// RF has priority; a saturating starvation counter forces DMA through after
// STARVE_LIMIT consecutive denied cycles. Reads are tagged with their owner and the
// tag rides a READ_LAT-deep pipe; when it leaves the pipe, mem_dat_r is captured
// into the owner's dat_r and its rvalid pulses, READ_LAT+1 cycles after the grant.
module dcache_port_arbiter #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned STRIDE_W     = 14,
   parameter int unsigned DATA_W       = 288,
   parameter int unsigned READ_LAT     = 3,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,   // active-low, asynchronous
   input  logic                 i_freeze,
   dcache_port_arbiter_if.slave bus
);
   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [STRIDE_W-1:0] r_mem_stride_x;
   logic [STRIDE_W-1:0] r_mem_stride_y;
   logic [DATA_W-1:0]   r_mem_dat_w;
   logic [CntW-1:0]     r_starve;
   logic [READ_LAT-1:0] r_tag_vld;
   logic [READ_LAT-1:0] r_tag_own;   // 1 = DMA owns the read
   logic                r_rf_rvalid;
   logic                r_dma_rvalid;
   logic [DATA_W-1:0]   r_rf_dat_r;
   logic [DATA_W-1:0]   r_dma_dat_r;

   logic w_rf_gnt;
   logic w_dma_gnt;
   logic w_issue_rd;
   logic w_starved;

   assign w_starved  = (r_starve == CntW'(STARVE_LIMIT));
   assign w_issue_rd = (w_rf_gnt && !bus.rf_we) || (w_dma_gnt && !bus.dma_we);

   // Grant selection: starved DMA first, then RF, then DMA; nothing in reset or freeze.
   always_comb begin
      w_rf_gnt  = 1'b0;
      w_dma_gnt = 1'b0;
      if (i_reset && !i_freeze) begin
         if (bus.dma_valid && w_starved) begin
            w_dma_gnt = 1'b1;
         end else if (bus.rf_valid) begin
            w_rf_gnt = 1'b1;
         end else if (bus.dma_valid) begin
            w_dma_gnt = 1'b1;
         end
      end
   end

   // Issue register: load the granted request; without a grant only en/we drop.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_mem_en       <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_stride_x <= '0;
         r_mem_stride_y <= '0;
         r_mem_dat_w    <= '0;
      end else begin
         r_mem_en <= w_rf_gnt || w_dma_gnt;
         r_mem_we <= 1'b0;
         if (w_rf_gnt) begin
            r_mem_we       <= bus.rf_we;
            r_mem_addr     <= bus.rf_addr;
            r_mem_stride_x <= bus.rf_stride_x;
            r_mem_stride_y <= bus.rf_stride_y;
            r_mem_dat_w    <= bus.rf_dat_w;
         end else if (w_dma_gnt) begin
            // DMA always moves contiguous lines
            r_mem_we       <= bus.dma_we;
            r_mem_addr     <= bus.dma_addr;
            r_mem_stride_x <= '0;
            r_mem_stride_y <= STRIDE_W'(1);
            r_mem_dat_w    <= bus.dma_dat_w;
         end
      end
   end

   // Starvation counter: counts denied DMA cycles, frozen cycles do not count.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_starve <= '0;
      end else if (!i_freeze) begin
         if (!bus.dma_valid || w_dma_gnt) begin
            r_starve <= '0;
         end else if (!w_starved) begin
            r_starve <= r_starve + CntW'(1);
         end
      end
   end

   // Read tag pipe and return routing; never stalled by freeze.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_tag_vld    <= '0;
         r_tag_own    <= '0;
         r_rf_rvalid  <= 1'b0;
         r_dma_rvalid <= 1'b0;
         r_rf_dat_r   <= '0;
         r_dma_dat_r  <= '0;
      end else begin
         r_tag_vld    <= {r_tag_vld[READ_LAT-2:0], w_issue_rd};
         r_tag_own    <= {r_tag_own[READ_LAT-2:0], w_dma_gnt};
         r_rf_rvalid  <= r_tag_vld[READ_LAT-1] && !r_tag_own[READ_LAT-1];
         r_dma_rvalid <= r_tag_vld[READ_LAT-1] && r_tag_own[READ_LAT-1];
         if (r_tag_vld[READ_LAT-1]) begin
            if (r_tag_own[READ_LAT-1]) begin
               r_dma_dat_r <= bus.mem_dat_r;
            end else begin
               r_rf_dat_r <= bus.mem_dat_r;
            end
         end
      end
   end

   assign bus.rf_ready     = w_rf_gnt;
   assign bus.dma_ready    = w_dma_gnt;
   assign bus.rf_rvalid    = r_rf_rvalid;
   assign bus.rf_dat_r     = r_rf_dat_r;
   assign bus.dma_rvalid   = r_dma_rvalid;
   assign bus.dma_dat_r    = r_dma_dat_r;
   assign bus.mem_en       = r_mem_en;
   assign bus.mem_we       = r_mem_we;
   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_stride_x = r_mem_stride_x;
   assign bus.mem_stride_y = r_mem_stride_y;
   assign bus.mem_dat_w    = r_mem_dat_w;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter. A reference model predicts grants and
// issued fields each cycle; granted reads push their expected return onto a
// scoreboard that is popped when the return is due. Memory read data is a
// per-cycle pattern so each return identifies the cycle it was captured on.
module tb_dcache_port_arbiter;
   localparam int unsigned ADDR_W       = 15;
   localparam int unsigned STRIDE_W     = 14;
   localparam int unsigned DATA_W       = 288;
   localparam int unsigned READ_LAT     = 3;
   localparam int unsigned STARVE_LIMIT = 4;

   typedef struct {
      int unsigned       due;
      logic              own;   // 1 = DMA
      logic [DATA_W-1:0] dat;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        freeze;
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail  = 0;
   rd_t         sb[$];

   // Model state
   int                  m_starve;
   logic                m_en, m_we;
   logic [ADDR_W-1:0]   m_addr;
   logic [STRIDE_W-1:0] m_sx, m_sy;
   logic [DATA_W-1:0]   m_dat_w, m_rf_dat, m_dma_dat;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dcache_port_arbiter_if #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .DATA_W(DATA_W)) bus ();

   assign bus.mem_dat_r = {9{cyc}};

   dcache_port_arbiter #(
      .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .DATA_W(DATA_W),
      .READ_LAT(READ_LAT), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .i_freeze(freeze),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      m_starve  = 0;
      m_en      = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_sx      = '0;
      m_sy      = '0;
      m_dat_w   = '0;
      m_rf_dat  = '0;
      m_dma_dat = '0;
      sb.delete();
   endtask

   // Compare one cycle against the model, then advance the model across the edge.
   task automatic evaluate();
      logic        e_rf, e_dma, e_rf_rv, e_dma_rv;
      logic [31:0] pat;
      rd_t         r;
      e_rf = 1'b0; e_dma = 1'b0; e_rf_rv = 1'b0; e_dma_rv = 1'b0;
      if (!rst_n) clear_model();
      if (rst_n && !freeze) begin
         if (bus.dma_valid && m_starve == STARVE_LIMIT) e_dma = 1'b1;
         else if (bus.rf_valid) e_rf = 1'b1;
         else if (bus.dma_valid) e_dma = 1'b1;
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         r = sb.pop_front();
         if (r.own) begin e_dma_rv = 1'b1; m_dma_dat = r.dat; end
         else begin e_rf_rv = 1'b1; m_rf_dat = r.dat; end
      end
      check("rf_ready",   DATA_W'(bus.rf_ready),   DATA_W'(e_rf));
      check("dma_ready",  DATA_W'(bus.dma_ready),  DATA_W'(e_dma));
      check("mem_en",     DATA_W'(bus.mem_en),     DATA_W'(m_en));
      check("mem_we",     DATA_W'(bus.mem_we),     DATA_W'(m_we));
      check("mem_fields", DATA_W'({bus.mem_addr, bus.mem_stride_x, bus.mem_stride_y}),
                          DATA_W'({m_addr, m_sx, m_sy}));
      check("mem_dat_w",  bus.mem_dat_w,           m_dat_w);
      check("rf_rvalid",  DATA_W'(bus.rf_rvalid),  DATA_W'(e_rf_rv));
      check("dma_rvalid", DATA_W'(bus.dma_rvalid), DATA_W'(e_dma_rv));
      check("rf_dat_r",   bus.rf_dat_r,            m_rf_dat);
      check("dma_dat_r",  bus.dma_dat_r,           m_dma_dat);
      if (rst_n) begin
         m_en = e_rf || e_dma;
         m_we = 1'b0;
         if (e_rf) begin
            m_we = bus.rf_we; m_addr = bus.rf_addr;
            m_sx = bus.rf_stride_x; m_sy = bus.rf_stride_y; m_dat_w = bus.rf_dat_w;
         end else if (e_dma) begin
            m_we = bus.dma_we; m_addr = bus.dma_addr;
            m_sx = '0; m_sy = STRIDE_W'(1); m_dat_w = bus.dma_dat_w;
         end
         if (m_en && !m_we) begin
            // data captured at the end of cycle grant+3, visible at grant+4
            pat = cyc + 3;
            sb.push_back('{due: cyc + 4, own: e_dma, dat: {9{pat}}});
         end
         if (!freeze) begin
            if (!bus.dma_valid || e_dma) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
         end
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         evaluate();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      clear_model();
      rst_n           = 1'b0;
      freeze          = 1'b0;
      bus.rf_valid    = 1'b0;
      bus.rf_we       = 1'b0;
      bus.rf_addr     = '0;
      bus.rf_stride_x = '0;
      bus.rf_stride_y = '0;
      bus.rf_dat_w    = '0;
      bus.dma_valid   = 1'b0;
      bus.dma_we      = 1'b0;
      bus.dma_addr    = '0;
      bus.dma_dat_w   = '0;
      step(2);
      rst_n = 1'b1;
      step(1);

      // RF read
      bus.rf_valid = 1'b1; bus.rf_we = 1'b0; bus.rf_addr = 15'h0010;
      bus.rf_stride_x = 14'd1; bus.rf_stride_y = 14'd4; bus.rf_dat_w = {9{32'hA5A5_0001}};
      step(1);
      bus.rf_valid = 1'b0;
      step(5);

      // Contention: both requesting reads for 10 cycles
      bus.rf_valid = 1'b1; bus.rf_addr = 15'h0100; bus.rf_stride_x = 14'd2;
      bus.dma_valid = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 15'h0200;
      bus.dma_dat_w = {9{32'h0D0D_0002}};
      step(10);
      bus.rf_valid = 1'b0; bus.dma_valid = 1'b0;
      step(6);

      // DMA write to the top address: no return expected
      bus.dma_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 15'h7FFF;
      bus.dma_dat_w = {9{32'hDEAD_BEEF}};
      step(1);
      bus.dma_valid = 1'b0; bus.dma_we = 1'b0;
      step(5);

      // Interleaved reads: RF then DMA on consecutive cycles
      bus.rf_valid = 1'b1; bus.rf_addr = 15'h0123; bus.rf_stride_y = 14'd7;
      step(1);
      bus.rf_valid = 1'b0; bus.dma_valid = 1'b1; bus.dma_addr = 15'h0456;
      step(1);
      bus.dma_valid = 1'b0;
      step(5);

      // Freeze with an RF read in flight and DMA waiting
      bus.rf_valid = 1'b1; bus.rf_addr = 15'h0040;
      step(1);
      bus.rf_valid = 1'b0; freeze = 1'b1; bus.dma_valid = 1'b1; bus.dma_addr = 15'h0050;
      step(2);
      bus.rf_valid = 1'b1;   // contention while frozen must not build starvation
      step(3);
      freeze = 1'b0;
      step(6);
      bus.rf_valid = 1'b0; bus.dma_valid = 1'b0;
      step(6);

      // Reset mid-read: the in-flight return is discarded
      bus.rf_valid = 1'b1; bus.rf_addr = 15'h0077;
      step(1);
      bus.rf_valid = 1'b0;
      step(1);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single tile-wide dcache memory port between two requesters: the regfile load/store path (RF) and the DMA engine (DMA).
- Grants at most one access per cycle; RF has priority, and a starvation counter guarantees DMA forward progress.
- Tracks in-flight reads through the fixed-latency memory pipeline and routes each read return back to the requester that issued it.
- Sits between the regfile/DMA stage logic and dcache_mem_high_priority.

Parameters:
- ADDR_W, 15, tile address width (10+LOGCNT).
- STRIDE_W, 14, stride width (10+LOGCNT-1).
- DATA_W, 288, tile data width (18*4*4).
- READ_LAT, 3, cycles from a granted read (mem_en high) to mem_dat_r valid.
- STARVE_LIMIT, 4, consecutive cycles DMA may be denied before it is forced through.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- freeze  in  1  stall; blocks new grants only.
- rf_valid  in  1  RF request.
- rf_ready  out  1  RF grant this cycle (combinational).
- rf_we  in  1  1=write, 0=read.
- rf_addr  in  ADDR_W  base address.
- rf_stride_x  in  STRIDE_W  x stride.
- rf_stride_y  in  STRIDE_W  y stride.
- rf_dat_w  in  DATA_W  write data.
- rf_rvalid  out  1  RF read data valid.
- rf_dat_r  out  DATA_W  RF read data.
- dma_valid  in  1  DMA request.
- dma_ready  out  1  DMA grant this cycle (combinational).
- dma_we  in  1  1=write.
- dma_addr  in  ADDR_W  address.
- dma_dat_w  in  DATA_W  write data.
- dma_rvalid  out  1  DMA read data valid.
- dma_dat_r  out  DATA_W  DMA read data.
- mem_en  out  1  access issued to memory (registered).
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_W  registered.
- mem_stride_x  out  STRIDE_W  registered.
- mem_stride_y  out  STRIDE_W  registered.
- mem_dat_w  out  DATA_W  registered.
- mem_dat_r  in  DATA_W  memory read data.

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs, the starve counter and the tag pipeline clear to 0. rf_ready and dma_ready are 0 while reset is asserted.
- Grant rule, evaluated combinationally each cycle:
  - If freeze=1, no grant is issued.
  - Otherwise, if dma_valid && starve_cnt==STARVE_LIMIT, DMA is granted.
  - Otherwise, if rf_valid, RF is granted.
  - Otherwise, if dma_valid, DMA is granted.
  - Exactly one of rf_ready/dma_ready is high when a grant occurs.
  - A transfer completes on a cycle where valid && ready. Requesters hold their fields stable until ready.
- Issue: on a grant, the mem_* registers load the granted request at the next edge and mem_en=1 for one cycle. With no grant, mem_en=0 and mem_we=0; the other mem_* fields hold.
- DMA strides: a DMA request issues with mem_stride_x=0 and mem_stride_y=1 (contiguous lines).
- Starve counter (saturating at STARVE_LIMIT):
  - Increments when dma_valid && !dma_ready && !freeze.
  - Clears when DMA is granted or dma_valid=0.
  - Holds while freeze=1.
- Read tracking: a READ_LAT-deep shift register of {valid, owner} tags is loaded at issue with valid = mem_en && !mem_we.
  - The tag pipeline always advances; freeze does not stall in-flight reads.
  - When the tag exits the pipeline, the owner's rvalid pulses for 1 cycle and its dat_r is registered from mem_dat_r.
  - The non-owner's rvalid stays 0 and its dat_r holds.
- Latency: grant at cycle T -> mem_en at T+1 -> rvalid at T+1+READ_LAT.
- Read returns arrive in issue order. At most one rvalid is high per cycle.
- Writes produce no return.
- Ordering between requesters is grant order. An RF read granted after a DMA write to the same address observes the new data; the memory supplies no forwarding, and none is required here.
- freeze asserted mid-stream: in-flight reads still return. New requests wait, and their ready stays 0.
- Reset asserted mid-operation: in-flight reads are discarded and no rvalid is produced for them.

Test Plan:
- RF read only: rf_valid=1, rf_addr=0x0010, rf_stride_x=1, rf_stride_y=4 -> rf_ready same cycle; mem_en=1, mem_addr=0x0010 next cycle; rf_rvalid exactly 4 cycles after the grant (READ_LAT=3) with rf_dat_r=mem_dat_r.
- Contention/starvation: rf_valid and dma_valid held high for 10 cycles -> RF granted cycles 0-3, DMA granted cycle 4, RF cycles 5-8, DMA cycle 9; dma_ready never low for more than 4 consecutive cycles.
- DMA write: dma_valid=1, dma_we=1, dma_addr=0x7FFF -> mem_we=1, mem_stride_x=0, mem_stride_y=1; no dma_rvalid or rf_rvalid follows.
- Interleaved reads: RF read at cycle 0, DMA read at cycle 1 -> rf_rvalid at cycle 4, dma_rvalid at cycle 5, never both high together.
- Freeze: RF read granted at cycle 0, freeze=1 during cycles 1-5 with dma_valid=1 -> rf_rvalid still at cycle 4; dma_ready=0 until freeze drops; the starve counter does not advance during freeze.
- Reset: reset=0 pulsed at cycle 2 after an RF read at cycle 0 -> all outputs 0 immediately; no rf_rvalid ever appears for that read.
